// File: rtl/lcd_scheduler.sv
// lcd_scheduler: plays the LCD power-up words, then shares the
// character-LCD handshake driver between two round-robin requesters.
module lcd_scheduler #(
  parameter int SETTLE_CYCLES = 262142,
  parameter int CNT_W         = 18
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iREQ_A,
  input  logic [8:0] iWORD_A,
  output logic       oACK_A,
  input  logic       iREQ_B,
  input  logic [8:0] iWORD_B,
  output logic       oACK_B,
  output logic [7:0] oDATA,
  output logic       oRS,
  output logic       oStart,
  input  logic       iDone,
  output logic       oREADY,
  output logic       oBUSY
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ARB,
    S_START,
    S_WAIT,
    S_SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [8:0]       word;

  // Power-up words: function set, display on, clear, entry mode, home.
  function automatic logic [8:0] rom(input logic [2:0] i);
    logic [8:0] w;
    case (i)
      3'd0:    w = 9'h038;
      3'd1:    w = 9'h00C;
      3'd2:    w = 9'h001;
      3'd3:    w = 9'h006;
      3'd4:    w = 9'h080;
      default: w = 9'h000;
    endcase
    return w;
  endfunction

  assign oDATA = word[7:0];
  assign oRS   = word[8];
  assign oBUSY = (state != S_ARB);

  // Sequencer: init replay, arbitration, start/wait handshake, settle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= S_INIT;
      idx    <= 3'd0;
      cnt    <= '0;
      last   <= 1'b1;
      word   <= 9'h000;
      oStart <= 1'b0;
      oACK_A <= 1'b0;
      oACK_B <= 1'b0;
      oREADY <= 1'b0;
    end else begin
      oACK_A <= 1'b0;
      oACK_B <= 1'b0;
      case (state)
        S_INIT: begin
          word  <= rom(idx);
          state <= S_START;
        end
        S_ARB: begin
          if (iREQ_A && (!iREQ_B || last)) begin
            word   <= iWORD_A;
            oACK_A <= 1'b1;
            last   <= 1'b0;
            state  <= S_START;
          end else if (iREQ_B) begin
            word   <= iWORD_B;
            oACK_B <= 1'b1;
            last   <= 1'b1;
            state  <= S_START;
          end
        end
        S_START: begin
          oStart <= 1'b1;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (iDone) begin
            oStart <= 1'b0;
            cnt    <= '0;
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == SETTLE_LAST) begin
            if (!oREADY) begin
              if (idx == 3'd4) begin
                oREADY <= 1'b1;
                state  <= S_ARB;
              end else begin
                idx   <= idx + 3'd1;
                state <= S_INIT;
              end
            end else begin
              state <= S_ARB;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_scheduler.sv
// tb_lcd_scheduler: directed bench for the LCD scheduler with a
// driver model that answers oStart with iDone three cycles later.
module tb_lcd_scheduler;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iREQ_A = 1'b0;
  logic [8:0] iWORD_A = 9'h000;
  logic       oACK_A;
  logic       iREQ_B = 1'b0;
  logic [8:0] iWORD_B = 9'h000;
  logic       oACK_B;
  logic [7:0] oDATA;
  logic       oRS;
  logic       oStart;
  logic       iDone;
  logic       oREADY;
  logic       oBUSY;

  logic       done_m = 1'b0;
  logic       inj = 1'b0;
  logic [1:0] dly = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_a = 0;
  int ack_b = 0;
  int both = 0;
  logic ps = 1'b0;

  int         st_cyc[$];
  logic [8:0] st_word[$];
  int         dn_edge[$];
  bit         gq[$];

  logic [8:0] init_w [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};

  lcd_scheduler #(
    .SETTLE_CYCLES(4),
    .CNT_W(18)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iREQ_A(iREQ_A),
    .iWORD_A(iWORD_A),
    .oACK_A(oACK_A),
    .iREQ_B(iREQ_B),
    .iWORD_B(iWORD_B),
    .oACK_B(oACK_B),
    .oDATA(oDATA),
    .oRS(oRS),
    .oStart(oStart),
    .iDone(iDone),
    .oREADY(oREADY),
    .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  assign iDone = done_m | inj;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Driver model: iDone one cycle, raised at the 3rd edge after oStart.
  always @(posedge iCLK) begin
    if (iRST || !oStart || done_m) begin
      dly <= 2'd0;
      done_m <= 1'b0;
    end else if (dly == 2'd2) begin
      done_m <= 1'b1;
    end else begin
      dly <= dly + 2'd1;
    end
  end

  // Event log: start edges with word, completion edges, grants.
  always @(negedge iCLK) begin
    if (oStart && !ps) begin
      st_cyc.push_back(cyc);
      st_word.push_back({oRS, oDATA});
    end
    ps = oStart;
    if (iDone && oStart) dn_edge.push_back(cyc + 1);
    if (oACK_A) begin ack_a++; gq.push_back(1'b0); end
    if (oACK_B) begin ack_b++; gq.push_back(1'b1); end
    if (oACK_A && oACK_B) both++;
  end

  task automatic step();
    @(posedge iCLK);
    #2;
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_word.delete();
    dn_edge.delete();
    gq.delete();
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    step(); step(); step();
    n_cmp++; if (oStart !== 1'b0) begin n_bad++; $display("FAIL reset_start got %b want 0", oStart); end
    n_cmp++; if (oDATA !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", oDATA); end
    n_cmp++; if (oRS !== 1'b0) begin n_bad++; $display("FAIL reset_rs got %b want 0", oRS); end
    n_cmp++; if (oACK_A !== 1'b0 || oACK_B !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b%b want 00", oACK_A, oACK_B); end
    n_cmp++; if (oREADY !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", oREADY); end
    n_cmp++; if (oBUSY !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", oBUSY); end
  endtask

  task automatic test_init();
    int rel;
    clear_log();
    rel = cyc;
    iRST = 1'b0;
    step();
    n_cmp++; if (oDATA !== 8'h38 || oRS !== 1'b0) begin n_bad++; $display("FAIL init_first_word got %b_%h want 0_38", oRS, oDATA); end
    n_cmp++; if (oStart !== 1'b0) begin n_bad++; $display("FAIL init_start_early got %b want 0", oStart); end
    step();
    n_cmp++; if (oStart !== 1'b1) begin n_bad++; $display("FAIL init_start_edge2 got %b want 1", oStart); end
    for (int i = 0; i < 300 && !oREADY; i++) step();
    n_cmp++; if (oREADY !== 1'b1) begin n_bad++; $display("FAIL init_ready_timeout got %b want 1", oREADY); end
    n_cmp++; if (st_word.size() != 5) begin n_bad++; $display("FAIL init_count got %0d want 5", st_word.size()); end
    for (int i = 0; i < 5 && i < st_word.size(); i++) begin
      n_cmp++;
      if (st_word[i] !== init_w[i]) begin n_bad++; $display("FAIL init_word%0d got %h want %h", i, st_word[i], init_w[i]); end
    end
    if (st_cyc.size() >= 2 && dn_edge.size() >= 5) begin
      n_cmp++; if (st_cyc[0] - rel != 2) begin n_bad++; $display("FAIL init_first_lat got %0d want 2", st_cyc[0] - rel); end
      n_cmp++; if (st_cyc[1] - dn_edge[0] != 6) begin n_bad++; $display("FAIL init_gap got %0d want 6", st_cyc[1] - dn_edge[0]); end
      n_cmp++; if (cyc - dn_edge[4] != 4) begin n_bad++; $display("FAIL init_ready_lat got %0d want 4", cyc - dn_edge[4]); end
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL init_events got %0d/%0d want 5/5", st_cyc.size(), dn_edge.size());
    end
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL init_idle_busy got %b want 0", oBUSY); end
  endtask

  task automatic test_round_robin();
    logic [8:0] ew [4] = '{9'h131, 9'h132, 9'h131, 9'h132};
    bit eg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_log();
    both = 0;
    iWORD_A = 9'h131;
    iWORD_B = 9'h132;
    iREQ_A = 1'b1;
    iREQ_B = 1'b1;
    for (int i = 0; i < 400 && gq.size() < 4; i++) step();
    iREQ_A = 1'b0;
    iREQ_B = 1'b0;
    for (int i = 0; i < 100 && oBUSY; i++) step();
    n_cmp++; if (gq.size() != 4) begin n_bad++; $display("FAIL rr_grants got %0d want 4", gq.size()); end
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      n_cmp++;
      if (gq[i] != eg[i]) begin n_bad++; $display("FAIL rr_order%0d got %0d want %0d", i, gq[i], eg[i]); end
    end
    n_cmp++; if (st_word.size() != 4 || dn_edge.size() != 4) begin n_bad++; $display("FAIL rr_words got %0d/%0d want 4/4", st_word.size(), dn_edge.size()); end
    for (int i = 0; i < 4 && i < st_word.size(); i++) begin
      n_cmp++;
      if (st_word[i] !== ew[i]) begin n_bad++; $display("FAIL rr_word%0d got %h want %h", i, st_word[i], ew[i]); end
    end
    n_cmp++; if (both != 0) begin n_bad++; $display("FAIL rr_dual_ack got %0d want 0", both); end
  endtask

  task automatic test_single();
    int a0;
    a0 = ack_a;
    iWORD_A = 9'h141;
    iREQ_A = 1'b1;
    step();
    n_cmp++; if (oACK_A !== 1'b1 || oACK_B !== 1'b0) begin n_bad++; $display("FAIL single_ack got %b%b want 10", oACK_A, oACK_B); end
    n_cmp++; if (oDATA !== 8'h41 || oRS !== 1'b1) begin n_bad++; $display("FAIL single_latch got %b_%h want 1_41", oRS, oDATA); end
    n_cmp++; if (oStart !== 1'b0 || oBUSY !== 1'b1) begin n_bad++; $display("FAIL single_grant_state got %b%b want 01", oStart, oBUSY); end
    iREQ_A = 1'b0;
    iWORD_A = 9'h000;
    step();
    n_cmp++; if (oACK_A !== 1'b0) begin n_bad++; $display("FAIL single_ack_len got %b want 0", oACK_A); end
    n_cmp++; if (oStart !== 1'b1 || oDATA !== 8'h41 || oRS !== 1'b1) begin n_bad++; $display("FAIL single_start got %b %b_%h want 1 1_41", oStart, oRS, oDATA); end
    n_cmp++; if (oBUSY !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", oBUSY); end
    for (int i = 0; i < 100 && oBUSY; i++) step();
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL single_idle got %b want 0", oBUSY); end
    n_cmp++; if (ack_a - a0 != 1) begin n_bad++; $display("FAIL single_ack_count got %0d want 1", ack_a - a0); end
  endtask

  task automatic test_back_to_back();
    int a0;
    int n0;
    bit injd;
    n0 = st_cyc.size();
    inj = 1'b1;
    step();
    inj = 1'b0;
    step(); step(); step(); step();
    n_cmp++; if (st_cyc.size() != n0 || oStart !== 1'b0) begin n_bad++; $display("FAIL idle_done_start got %0d want %0d", st_cyc.size(), n0); end
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL idle_done_busy got %b want 0", oBUSY); end
    clear_log();
    injd = 1'b0;
    a0 = ack_a;
    iWORD_A = 9'h0AA;
    iREQ_A = 1'b1;
    for (int i = 0; i < 400 && (ack_a - a0) < 2; i++) begin
      if (ack_a - a0 == 1) iWORD_A = 9'h0AB;
      if (!injd && st_cyc.size() == 1 && !oStart && oBUSY) begin
        inj = 1'b1;
        injd = 1'b1;
      end else begin
        inj = 1'b0;
      end
      step();
    end
    inj = 1'b0;
    iREQ_A = 1'b0;
    for (int i = 0; i < 100 && oBUSY; i++) step();
    n_cmp++; if (!injd) begin n_bad++; $display("FAIL b2b_inject got %b want 1", injd); end
    n_cmp++; if (ack_a - a0 != 2) begin n_bad++; $display("FAIL b2b_acks got %0d want 2", ack_a - a0); end
    n_cmp++; if (st_word.size() != 2) begin n_bad++; $display("FAIL b2b_starts got %0d want 2", st_word.size()); end
    if (st_word.size() == 2 && dn_edge.size() >= 1) begin
      n_cmp++; if (st_word[0] !== 9'h0AA) begin n_bad++; $display("FAIL b2b_word0 got %h want 0aa", st_word[0]); end
      n_cmp++; if (st_word[1] !== 9'h0AB) begin n_bad++; $display("FAIL b2b_word1 got %h want 0ab", st_word[1]); end
      n_cmp++; if (st_cyc[1] - dn_edge[0] != 6) begin n_bad++; $display("FAIL b2b_gap got %0d want 6", st_cyc[1] - dn_edge[0]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int b0;
    int early;
    b0 = ack_b;
    early = 0;
    iWORD_B = 9'h142;
    iREQ_B = 1'b1;
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    clear_log();
    for (int i = 0; i < 200 && st_cyc.size() < 3; i++) step();
    n_cmp++; if (oStart !== 1'b1 || st_cyc.size() != 3) begin n_bad++; $display("FAIL rst_pre_wait got %b/%0d want 1/3", oStart, st_cyc.size()); end
    iRST = 1'b1;
    step();
    n_cmp++; if (oStart !== 1'b0 || oREADY !== 1'b0) begin n_bad++; $display("FAIL rst_mid_wait got %b%b want 00", oStart, oREADY); end
    n_cmp++; if (oBUSY !== 1'b1 || oDATA !== 8'h00) begin n_bad++; $display("FAIL rst_mid_state got %b %h want 1 00", oBUSY, oDATA); end
    iRST = 1'b0;
    clear_log();
    for (int i = 0; i < 300 && !oREADY; i++) begin
      if (ack_b != b0) early++;
      step();
    end
    n_cmp++; if (oREADY !== 1'b1) begin n_bad++; $display("FAIL rst_ready_timeout got %b want 1", oREADY); end
    n_cmp++; if (early != 0 || ack_b != b0) begin n_bad++; $display("FAIL rst_early_ack got %0d want 0", ack_b - b0); end
    for (int i = 0; i < 100 && ack_b == b0; i++) step();
    iREQ_B = 1'b0;
    for (int i = 0; i < 100 && oBUSY; i++) step();
    n_cmp++; if (st_word.size() != 6) begin n_bad++; $display("FAIL rst_replay_count got %0d want 6", st_word.size()); end
    for (int i = 0; i < 5 && i < st_word.size(); i++) begin
      n_cmp++;
      if (st_word[i] !== init_w[i]) begin n_bad++; $display("FAIL rst_replay%0d got %h want %h", i, st_word[i], init_w[i]); end
    end
    if (st_word.size() == 6) begin
      n_cmp++; if (st_word[5] !== 9'h142) begin n_bad++; $display("FAIL rst_b_first got %h want 142", st_word[5]); end
    end
    n_cmp++; if (ack_b - b0 != 1) begin n_bad++; $display("FAIL rst_b_acks got %0d want 1", ack_b - b0); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_round_robin();
    test_single();
    test_back_to_back();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_scheduler.md
# lcd_scheduler

Sequencer and arbiter for the character-LCD handshake driver (`lcd`, ports iDATA/iRS/iStart/oDone). After reset it plays the power-up initialisation words into the driver. It then shares the driver between two independent requesters, A and B, for example the ULA result writer and the letter writer. Each requester submits one 9-bit word `{RS, byte}` at a time. The scheduler issues each word to the driver, waits for completion, and holds a settle delay before the next word.

## Interface
Parameters:
- SETTLE_CYCLES, 262142 (18'h3FFFE): idle cycles after every driver `oDone` before the next word may start; must be ≥ 1.
- CNT_W, 18: width of the settle counter.

Ports:
- iCLK  in  1  single clock (CLOCK_50 at top level); all logic on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iREQ_A  in  1  requester A has a word pending; held high until oACK_A.
- iWORD_A  in  9  requester A word: bit 8 = RS, bits 7:0 = data/instruction.
- oACK_A  out  1  one-cycle pulse: A's word was latched.
- iREQ_B, iWORD_B, oACK_B: same as the A ports, for requester B.
- oDATA  out  8  to driver iDATA.
- oRS  out  1  to driver iRS.
- oStart  out  1  to driver iStart.
- iDone  in  1  from driver oDone.
- oREADY  out  1  high once the init sequence has completed; stays high until reset.
- oBUSY  out  1  high whenever state ≠ ARB.

## Operation
- Init ROM, 5 words, issued in order: 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080.
- States:
  - INIT: latch rom[idx] into the word register; go to START.
  - ARB: grant one requester; latch its word; pulse its ACK; go to START. With no request, stay in ARB.
  - START: drive oStart=1; go to WAIT.
  - WAIT: on sampling iDone=1, drive oStart=0, clear the counter, go to SETTLE.
  - SETTLE: increment the counter. When counter = SETTLE_CYCLES−1:
    - if init is in progress and idx<4: idx+1, go to INIT;
    - if init is in progress and idx=4: set oREADY, go to ARB;
    - otherwise go to ARB.
- Arbitration is round-robin with a one-bit `last` pointer.
  - Only one requester active: it wins.
  - Both active: the requester not granted last wins.
  - After reset, `last`=B, so A wins the first tie.
  - `last` updates only on a grant.
- iWORD_x is sampled only on the grant edge. It may change freely after oACK_x.
- A requester that drops iREQ before being granted is simply not granted. No error is raised.
- Requests are ignored in every state except ARB, including during init. Requests raised during init are served after oREADY rises.
- iDone is ignored outside WAIT.
- oStart is held high through WAIT until iDone is sampled. There is no timeout.
- oDATA/oRS are driven from the word register and remain stable from START until the next latch.

## Timing
- Reset values: oStart=0, oDATA=8'h00, oRS=0, oACK_A=oACK_B=0, oREADY=0, oBUSY=1 (state INIT), idx=0, counter=0, last=B.
- Reset asserted at any point, including mid-WAIT or mid-SETTLE, returns to the reset values on the next edge. Init then restarts from word 0.
- First word after reset release:
  - INIT occupies the first cycle; oStart rises at the 2nd edge after reset is released.
  - oDATA=8'h38 and oRS=0 are valid from the 1st edge after release.
- Grant latency: iREQ_x is sampled high in ARB at edge k. oACK_x is high during cycle k..k+1 (exactly one cycle). oDATA/oRS update at edge k. oStart rises at edge k+1.
- Completion: iDone sampled at edge d. oStart falls at d. The first possible oStart of the next word is at edge d+SETTLE_CYCLES+2 (the return to ARB adds one cycle, plus one for START).
- Back-to-back requests from one requester hold iREQ high continuously. Each word costs one oACK, and a new word is re-latched only in ARB.
- oACK_A and oACK_B are never high in the same cycle.

## Test plan
Bench setting: SETTLE_CYCLES=4 throughout, with a driver model that raises iDone 3 cycles after oStart.
- Reset release, no requests → oStart pulses five times. oDATA sequence is 38, 0C, 01, 06, 80, all with oRS=0. oREADY rises 4 cycles after the 5th iDone.
- After oREADY, iREQ_A=1 with iWORD_A=9'h141 → oACK_A one cycle at the grant edge. Next cycle: oStart=1, oDATA=8'h41, oRS=1. oBUSY=1 until return to ARB.
- iREQ_A and iREQ_B both held high with words 9'h131 and 9'h132 → grant order A, B, A, B. The oACK pulses alternate, and no oACK is issued without a completed word.
- iREQ_B held high during init → no oACK_B before oREADY; B's word is the first word issued after init.
- iRST pulsed for 1 cycle during WAIT of the 3rd init word → oStart=0 and oREADY=0 next edge. Init restarts at 9'h038, and all five words are replayed.
- iDone pulsed while in SETTLE or ARB → no state change and no extra oStart. The measured gap from iDone to the next oStart equals SETTLE_CYCLES+2.
